// File: rtl/reorder_buffer.sv
// Purpose: circular in-order reorder buffer between issue/CDB and the write-results stage.
// Latency: CDB write to head valid_out is 1 cycle (0 cycles with ROB_BYPASS_EN); ready alloc at empty is 1 cycle.
// Backpressure: full refuses allocation (pre-edge count); head only leaves on RE_in while valid_out is high.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous clear of every entry; wins over all other activity
//   alloc_valid/opcode/dest/ready  allocation request; alloc_ready marks an entry that needs no CDB result
//   alloc_tag                  index the next allocation receives (current tail)
//   full, empty                occupancy flags derived from count
//   cdb_valid/tag/value        result broadcast; only lands in a busy entry
//   valid_out, opcode_out, dest_out, value_out  head entry presented to write_results
//   RE_in                      retire the head entry (honoured only while valid_out)
//
// Optional feature macro: ROB_BYPASS_EN forwards a CDB result aimed at the head straight to
// valid_out/value_out in the same cycle.

module reorder_buffer #(
    parameter int data_width   = 16,
    parameter int tag_width    = 3,
    parameter int opcode_width = 4,
    parameter int reg_width    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,

    input  logic                    alloc_valid,
    input  logic [opcode_width-1:0] alloc_opcode,
    input  logic [reg_width-1:0]    alloc_dest,
    input  logic                    alloc_ready,
    output logic [tag_width-1:0]    alloc_tag,
    output logic                    full,
    output logic                    empty,

    input  logic                    cdb_valid,
    input  logic [tag_width-1:0]    cdb_tag,
    input  logic [data_width-1:0]   cdb_value,

    output logic                    valid_out,
    output logic [opcode_width-1:0] opcode_out,
    output logic [reg_width-1:0]    dest_out,
    output logic [data_width-1:0]   value_out,
    input  logic                    RE_in
);

    localparam int DEPTH = 1 << tag_width;
    // count is one bit wider than a tag so that DEPTH itself is representable.
    localparam logic [tag_width:0] FULL_COUNT = {1'b1, {tag_width{1'b0}}};

    // Per-entry state.
    logic [DEPTH-1:0]        busy;
    logic [DEPTH-1:0]        ready;
    logic [opcode_width-1:0] opcode_q [DEPTH];
    logic [reg_width-1:0]    dest_q   [DEPTH];
    logic [data_width-1:0]   value_q  [DEPTH];

    logic [tag_width-1:0]    head;
    logic [tag_width-1:0]    tail;
    logic [tag_width:0]      count;

    logic                    alloc_fire;
    logic                    wb_fire;
    logic                    retire_fire;
    logic                    head_bypass;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign alloc_tag = tail;

`ifdef ROB_BYPASS_EN
    // CDB result for the head can be consumed in the same cycle it is broadcast.
    assign head_bypass = cdb_valid && (cdb_tag == head) && busy[head];
`else
    assign head_bypass = 1'b0;
`endif

    always_comb begin
        valid_out  = busy[head] && (ready[head] || head_bypass);
        opcode_out = opcode_q[head];
        dest_out   = dest_q[head];
        value_out  = head_bypass ? cdb_value : value_q[head];
    end

    // Full is judged on the pre-edge count, so a retire in the same cycle does not
    // open a slot for this cycle's allocation.
    assign alloc_fire  = alloc_valid && !full;
    assign retire_fire = RE_in && valid_out;
    // A bypassed result that retires immediately has nowhere left to be written.
    assign wb_fire     = cdb_valid && busy[cdb_tag] && !(head_bypass && retire_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            ready <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opcode_q[i] <= '0;
                dest_q[i]   <= '0;
                value_q[i]  <= '0;
            end
        end else if (flush) begin
            busy  <= '0;
            ready <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wb_fire) begin
                value_q[cdb_tag] <= cdb_value;
                ready[cdb_tag]   <= 1'b1;
            end

            // The tail slot is never busy when allocation is allowed, so it cannot
            // collide with a writeback or retire of a live entry.
            if (alloc_fire) begin
                busy[tail]     <= 1'b1;
                ready[tail]    <= alloc_ready;
                opcode_q[tail] <= alloc_opcode;
                dest_q[tail]   <= alloc_dest;
                value_q[tail]  <= '0;
                tail           <= tail + 1'b1;
            end

            // Placed last so that freeing the head wins over a late CDB write to it.
            if (retire_fire) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
                head        <= head + 1'b1;
            end

            case ({alloc_fire, retire_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
